membus_master: RTL and testbench

//  Processor-side initiator for the membus core-memory protocol. Converts a simple

---
 rtl/membus_master_if.sv | 57 +++++
 rtl/membus_master.sv | 206 ++++++++++++++++++++
 tb/tb_membus_master.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/membus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : membus_master_if
// Description : Bundle for the membus master. Carries the client request
//               side (req/rdata/done) and the membus core-memory side
//               (rq_cyc/rd_rq/wr_rq/ma/sel/mb_out/wr_rs, addr_ack/rd_rs/mb_in).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Modports
//   master : view of membus_master (drives busy/rdata/done and membus outputs)
//   slave  : view of the client plus core memory (drives req and membus inputs)
// Bit numbering follows the host machine: bit 0 is the word MSB.
// ============================================================================
interface membus_master_if;
  // client request side
  logic         req;
  logic         req_rd;
  logic         req_wr;
  logic [18:35] req_addr;
  logic         req_fmc_en;
  logic [0:35]  wdata;
  logic         wdata_stb;
  logic         busy;
  logic [0:35]  rdata;
  logic         rd_done;
  logic         done;
  logic         nxm;
  // membus side
  logic         membus_rq_cyc;
  logic         membus_rd_rq;
  logic         membus_wr_rq;
  logic [21:35] membus_ma;
  logic [18:21] membus_sel;
  logic         membus_fmc_select;
  logic [0:35]  membus_mb_out;
  logic         membus_wr_rs;
  logic         membus_addr_ack;
  logic         membus_rd_rs;
  logic [0:35]  membus_mb_in;

  modport master (
    input  req, req_rd, req_wr, req_addr, req_fmc_en, wdata, wdata_stb,
    output busy, rdata, rd_done, done, nxm,
    output membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_ma, membus_sel,
    output membus_fmc_select, membus_mb_out, membus_wr_rs,
    input  membus_addr_ack, membus_rd_rs, membus_mb_in
  );

  modport slave (
    output req, req_rd, req_wr, req_addr, req_fmc_en, wdata, wdata_stb,
    input  busy, rdata, rd_done, done, nxm,
    input  membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_ma, membus_sel,
    input  membus_fmc_select, membus_mb_out, membus_wr_rs,
    output membus_addr_ack, membus_rd_rs, membus_mb_in
  );
endinterface
`default_nettype wire

// File: rtl/membus_master.sv
`default_nettype none
// ============================================================================
// Module      : membus_master
// Description : Processor-side initiator for the membus core-memory protocol.
//               Turns a read / write / read-modify-write request into the
//               rq_cyc / rd_rq / wr_rq / ma / sel sequence, collects read data
//               until rd_rs, drives write data then wr_rs, and flags
//               non-existent memory when addr_ack or rd_rs never arrives.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in  system clock
//   reset  in  asynchronous active-high reset; abandons any cycle in flight
//   bus    membus_master_if.master - client request and membus signals
// Parameters
//   NXM_CYC   cycles to wait for addr_ack before flagging NXM
//   DATA_CYC  cycles write data is driven on membus_mb_out
//   RS_CYC    cycles to wait for rd_rs before flagging NXM
// ============================================================================
module membus_master #(
  parameter int NXM_CYC  = 1000,
  parameter int DATA_CYC = 2,
  parameter int RS_CYC   = 4000
) (
  input  logic            clk,
  input  logic            reset,
  membus_master_if.master bus
);

  localparam int c_max_ab  = (NXM_CYC > RS_CYC) ? NXM_CYC : RS_CYC;
  localparam int c_max_cyc = (c_max_ab > DATA_CYC) ? c_max_ab : DATA_CYC;
  localparam int c_tw      = $clog2(c_max_cyc + 1);

  localparam logic [c_tw-1:0] c_nxm_last  = c_tw'(NXM_CYC - 1);
  localparam logic [c_tw-1:0] c_rs_last   = c_tw'(RS_CYC - 1);
  localparam logic [c_tw-1:0] c_data_last = c_tw'(DATA_CYC - 1);
  localparam logic [c_tw-1:0] c_one       = c_tw'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RQ       = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_RMW_WAIT = 3'd3,
    S_WR_DATA  = 3'd4,
    S_WR_GAP   = 3'd5,
    S_WR_RS    = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_tw-1:0] r_timer;
  logic [c_tw-1:0] w_timer_nxt;
  logic            w_set_nxm;

  logic [18:35]    r_addr;
  logic            r_rd;
  logic            r_wr;
  logic            r_fmc_sel;
  logic [0:35]     r_wdata;
  logic [0:35]     r_rdata;
  logic            r_nxm;

  logic            w_accept;
  logic            w_in_rq;
  logic            w_stb_take;

  // A request with neither mode bit set is not a cycle and is dropped.
  assign w_accept   = (r_state == S_IDLE) && bus.req && (bus.req_rd || bus.req_wr);
  assign w_in_rq    = (r_state == S_RQ);
  assign w_stb_take = (r_state == S_RMW_WAIT) && bus.wdata_stb;

  // --------------------------------------------------------------------------
  // State and cycle timer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // The single timer is reused by RQ, RD_WAIT and WR_DATA; every transition
  // into one of those states clears it so each starts counting from zero.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_set_nxm   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RQ;
          w_timer_nxt = '0;
        end
      end
      S_RQ: begin
        // Ack is tested first so an ack on the final timeout cycle wins.
        if (bus.membus_addr_ack) begin
          w_state_nxt = r_rd ? S_RD_WAIT : S_WR_DATA;
          w_timer_nxt = '0;
        end else if (r_timer == c_nxm_last) begin
          w_state_nxt = S_DONE;
          w_timer_nxt = '0;
          w_set_nxm   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + c_one;
        end
      end
      S_RD_WAIT: begin
        if (bus.membus_rd_rs) begin
          w_state_nxt = r_wr ? S_RMW_WAIT : S_DONE;
          w_timer_nxt = '0;
        end else if (r_timer == c_rs_last) begin
          w_state_nxt = S_DONE;
          w_timer_nxt = '0;
          w_set_nxm   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + c_one;
        end
      end
      S_RMW_WAIT: begin
        if (bus.wdata_stb) begin
          w_state_nxt = S_WR_DATA;
          w_timer_nxt = '0;
        end
      end
      S_WR_DATA: begin
        if (r_timer == c_data_last) begin
          w_state_nxt = S_WR_GAP;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + c_one;
        end
      end
      S_WR_GAP: w_state_nxt = S_WR_RS;
      S_WR_RS:  w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request, write data and read data registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_fmc_sel <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_nxm     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= bus.req_addr;
        r_rd      <= bus.req_rd;
        r_wr      <= bus.req_wr;
        // Fast memory covers word addresses 0..017 only.
        r_fmc_sel <= bus.req_fmc_en && (bus.req_addr[18:31] == '0);
        r_rdata   <= '0;
        r_nxm     <= 1'b0;
        // RMW write data arrives later on wdata_stb, not with the request.
        if (bus.req_wr && !bus.req_rd) begin
          r_wdata <= bus.wdata;
        end
      end
      if (w_stb_take) begin
        r_wdata <= bus.wdata;
      end
      // mb_in is a pulsed OR-bus: accumulate every cycle, including the
      // rd_rs cycle, since data bits may land on different cycles.
      if (r_state == S_RD_WAIT) begin
        r_rdata <= r_rdata | bus.membus_mb_in;
      end
      if (w_set_nxm) begin
        r_nxm <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from state so an asynchronous reset drops them at once
  // --------------------------------------------------------------------------
  assign bus.busy              = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.rdata             = r_rdata;
  assign bus.rd_done           = (r_state == S_RD_WAIT) && bus.membus_rd_rs;
  assign bus.done              = (r_state == S_DONE);
  assign bus.nxm               = (r_state == S_DONE) && r_nxm;

  assign bus.membus_rq_cyc     = w_in_rq;
  assign bus.membus_rd_rq      = w_in_rq && r_rd;
  assign bus.membus_wr_rq      = w_in_rq && r_wr;
  assign bus.membus_ma         = w_in_rq ? r_addr[21:35] : '0;
  assign bus.membus_sel        = w_in_rq ? r_addr[18:21] : '0;
  assign bus.membus_fmc_select = w_in_rq && r_fmc_sel;
  // The one-cycle zero after the data phase (WR_GAP) gives the core a
  // falling edge on |mb_in before wr_rs.
  assign bus.membus_mb_out     = (r_state == S_WR_DATA) ? r_wdata : '0;
  assign bus.membus_wr_rs      = (r_state == S_WR_RS);

endmodule
`default_nettype wire

// File: tb/tb_membus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_membus_master
// Description : Self-checking bench for membus_master. Each transaction's
//               expected timeline (rq cycles, data window, wr_rs, rd_done,
//               done, nxm, rdata) is computed from the protocol rules and
//               compared with what the DUT shows on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_membus_master;
  localparam int NXM_CYC  = 24;
  localparam int DATA_CYC = 2;
  localparam int RS_CYC   = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  membus_master_if bus ();

  membus_master #(
    .NXM_CYC (NXM_CYC),
    .DATA_CYC(DATA_CYC),
    .RS_CYC  (RS_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [0:35] rnd36();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[35:0];
  endfunction

  function automatic logic [18:35] rnd18();
    logic [31:0] v;
    v = $urandom;
    return v[17:0];
  endfunction

  task automatic idle_inputs();
    bus.req             = 1'b0;
    bus.req_rd          = 1'b0;
    bus.req_wr          = 1'b0;
    bus.req_addr        = '0;
    bus.req_fmc_en      = 1'b0;
    bus.wdata           = '0;
    bus.wdata_stb       = 1'b0;
    bus.membus_addr_ack = 1'b0;
    bus.membus_rd_rs    = 1'b0;
    bus.membus_mb_in    = '0;
  endtask

  // a: RQ cycle carrying addr_ack (>= NXM_CYC means memory never answers)
  // r: RD_WAIT cycle carrying rd_rs (>= RS_CYC means it never comes)
  // s: RMW_WAIT cycles before wdata_stb
  task automatic run_txn(input string nm, input bit rd, input bit wr,
                         input logic [18:35] addr, input bit fmc,
                         input logic [0:35] wd, input logic [0:35] rdval,
                         input int a, input int r, input int s);
    bit          ack, rs_ok, exp_nxm, exp_fmc;
    int          exp_done, exp_rq, exp_rd_done, exp_data_start, exp_wr_rs;
    int          exp_data_cnt, t;
    logic [0:35] exp_rdata, mask, rdata0;
    int rq_cnt, sig_err, busy_err, done_at, done_cnt, nxm_stray, rd_done_at;
    int rd_done_cnt, data_cnt, data_err, data_start, wr_rs_at, wr_rs_cnt;
    logic nxm_at_done;

    ack   = (a < NXM_CYC);
    rs_ok = (r < RS_CYC);
    exp_rq         = ack ? a + 1 : NXM_CYC;
    exp_rd_done    = -1;
    exp_data_start = -1;
    exp_wr_rs      = -1;
    exp_nxm        = 1'b0;
    exp_rdata      = '0;
    t              = -1;
    if (!ack) begin
      exp_done = NXM_CYC;
      exp_nxm  = 1'b1;
    end else if (!rd) begin
      exp_data_start = a + 1;
      exp_wr_rs      = a + 1 + DATA_CYC + 1;
      exp_done       = exp_wr_rs + 1;
    end else if (!rs_ok) begin
      exp_done = a + 1 + RS_CYC;
      exp_nxm  = 1'b1;
    end else begin
      t           = a + 1 + r;
      exp_rd_done = t;
      exp_rdata   = rdval;
      if (!wr) begin
        exp_done = t + 1;
      end else begin
        exp_data_start = t + 2 + s;
        exp_wr_rs      = exp_data_start + DATA_CYC + 1;
        exp_done       = exp_wr_rs + 1;
      end
    end
    exp_data_cnt = (exp_data_start >= 0 && wd != '0) ? DATA_CYC : 0;
    if (exp_data_cnt == 0) exp_data_start = -1;
    exp_fmc = fmc && (addr < 18'o20);
    mask    = rnd36();

    rq_cnt = 0; sig_err = 0; busy_err = 0; done_at = -1; done_cnt = 0;
    nxm_stray = 0; rd_done_at = -1; rd_done_cnt = 0; data_cnt = 0;
    data_err = 0; data_start = -1; wr_rs_at = -1; wr_rs_cnt = 0;
    nxm_at_done = 1'b0; rdata0 = 'x;

    @(negedge clk);
    idle_inputs();
    bus.req        = 1'b1;
    bus.req_rd     = rd;
    bus.req_wr     = wr;
    bus.req_addr   = addr;
    bus.req_fmc_en = fmc;
    bus.wdata      = (wr && !rd) ? wd : rnd36();

    for (int c = 0; c <= exp_done + 2; c++) begin
      @(negedge clk);
      // a second request while busy must be ignored
      bus.req             = (c < 2);
      bus.req_addr        = (c < 2) ? rnd18() : '0;
      bus.wdata           = rnd36();
      bus.wdata_stb       = 1'b0;
      bus.membus_addr_ack = 1'b0;
      bus.membus_rd_rs    = 1'b0;
      bus.membus_mb_in    = '0;
      if (ack && c == a) bus.membus_addr_ack = 1'b1;
      if (ack && c == a + 1 && (!rd || r > 0)) bus.membus_addr_ack = 1'b1;
      if (c == 0 && a > 0) bus.membus_rd_rs = 1'b1;
      if (c <= a) bus.membus_mb_in = rnd36();
      if (rd && ack && rs_ok) begin
        if (c == t) begin
          bus.membus_rd_rs = 1'b1;
          bus.membus_mb_in = (r > 0) ? (rdval & ~mask) : rdval;
        end else if (c == t - 1 && r > 0) begin
          bus.membus_mb_in = rdval & mask;
        end
      end
      if (rd && ack && r > 0 && c == a + 1) bus.wdata_stb = 1'b1;
      if (rd && wr && ack && rs_ok && c == t + 1 + s) begin
        bus.wdata_stb = 1'b1;
        bus.wdata     = wd;
      end
      #1;
      if (c == 0) rdata0 = bus.rdata;
      if (bus.busy !== (c < exp_done)) busy_err++;
      if (bus.membus_rq_cyc === 1'b1) begin
        rq_cnt++;
        if (bus.membus_rd_rq !== rd || bus.membus_wr_rq !== wr ||
            bus.membus_ma !== addr[21:35] || bus.membus_sel !== addr[18:21] ||
            bus.membus_fmc_select !== exp_fmc) sig_err++;
      end else if (bus.membus_rd_rq !== 1'b0 || bus.membus_wr_rq !== 1'b0 ||
                   bus.membus_ma !== '0 || bus.membus_sel !== '0 ||
                   bus.membus_fmc_select !== 1'b0) begin
        sig_err++;
      end
      if (bus.membus_mb_out !== '0) begin
        data_cnt++;
        if (data_start < 0) data_start = c;
        if (bus.membus_mb_out !== wd) data_err++;
      end
      if (bus.membus_wr_rs === 1'b1) begin
        wr_rs_cnt++;
        if (wr_rs_at < 0) wr_rs_at = c;
      end
      if (bus.rd_done === 1'b1) begin
        rd_done_cnt++;
        if (rd_done_at < 0) rd_done_at = c;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at     = c;
          nxm_at_done = bus.nxm;
        end
      end else if (bus.nxm !== 1'b0) begin
        nxm_stray++;
      end
    end
    idle_inputs();

    check({nm, ".rdata_clear"}, rdata0, 0);
    check({nm, ".rq_cycles"},   rq_cnt, exp_rq);
    check({nm, ".rq_signals"},  sig_err, 0);
    check({nm, ".busy"},        busy_err, 0);
    check({nm, ".done_at"},     done_at, exp_done);
    check({nm, ".done_cnt"},    done_cnt, 1);
    check({nm, ".nxm"},         nxm_at_done, exp_nxm);
    check({nm, ".nxm_stray"},   nxm_stray, 0);
    check({nm, ".rd_done_at"},  rd_done_at, exp_rd_done);
    check({nm, ".rd_done_cnt"}, rd_done_cnt, (exp_rd_done >= 0) ? 1 : 0);
    check({nm, ".data_cycles"}, data_cnt, exp_data_cnt);
    check({nm, ".data_start"},  data_start, exp_data_start);
    check({nm, ".data_value"},  data_err, 0);
    check({nm, ".wr_rs_at"},    wr_rs_at, exp_wr_rs);
    check({nm, ".wr_rs_cnt"},   wr_rs_cnt, (exp_wr_rs >= 0) ? 1 : 0);
    check({nm, ".rdata"},       bus.rdata, exp_rdata);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ".busy"},    bus.busy, 0);
    check({nm, ".done"},    bus.done, 0);
    check({nm, ".nxm"},     bus.nxm, 0);
    check({nm, ".rd_done"}, bus.rd_done, 0);
    check({nm, ".rdata"},   bus.rdata, 0);
    check({nm, ".rq_cyc"},  bus.membus_rq_cyc, 0);
    check({nm, ".rd_rq"},   bus.membus_rd_rq, 0);
    check({nm, ".wr_rq"},   bus.membus_wr_rq, 0);
    check({nm, ".ma"},      bus.membus_ma, 0);
    check({nm, ".sel"},     bus.membus_sel, 0);
    check({nm, ".fmc"},     bus.membus_fmc_select, 0);
    check({nm, ".mb_out"},  bus.membus_mb_out, 0);
    check({nm, ".wr_rs"},   bus.membus_wr_rs, 0);
  endtask

  initial begin
    bit          rd, wr, fmc;
    int          mode, a, r, s, busy_seen;
    logic [18:35] addr;
    logic [0:35]  wd, rdval;

    // Reset state
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("in_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("after_reset");

    // Directed transactions
    run_txn("read",  1'b1, 1'b0, 18'o001234, 1'b0, '0, 36'o0123456701234, 3, 2, 0);
    run_txn("write", 1'b0, 1'b1, 18'o000100, 1'b0, 36'o0777777000001, '0, 1, 0, 0);
    run_txn("rmw",   1'b1, 1'b1, 18'o000050, 1'b0, 36'd6, 36'd5, 2, 1, 2);
    run_txn("nxm_bank3", 1'b1, 1'b0, 18'o060000, 1'b0, '0, 36'o0123, NXM_CYC, 0, 0);
    run_txn("fmc_on",  1'b0, 1'b1, 18'o000012, 1'b1, 36'o17, '0, 0, 0, 0);
    run_txn("fmc_off", 1'b1, 1'b0, 18'o000012, 1'b0, '0, 36'o55, 0, 0, 0);
    run_txn("fmc_high", 1'b1, 1'b0, 18'o000020, 1'b1, '0, 36'o1, 1, 0, 0);
    run_txn("rs_timeout", 1'b1, 1'b0, 18'o000400, 1'b0, '0, 36'o7, 0, RS_CYC, 0);
    run_txn("ack_last", 1'b0, 1'b1, 18'o000777, 1'b0, 36'o3, '0, NXM_CYC - 1, 0, 0);
    run_txn("wr_zero", 1'b0, 1'b1, 18'o000300, 1'b0, '0, '0, 2, 0, 0);

    // Request with neither mode bit is ignored
    @(negedge clk);
    bus.req = 1'b1;
    bus.req_addr = 18'o000123;
    busy_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.req = 1'b0;
      #1;
      if (bus.busy !== 1'b0 || bus.membus_rq_cyc !== 1'b0) busy_seen++;
    end
    idle_inputs();
    check("no_mode.ignored", busy_seen, 0);

    // Reset while in WR_DATA drops everything at once
    @(negedge clk);
    bus.req = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 18'o000200;
    bus.wdata = 36'o1234;
    @(negedge clk);
    bus.req = 1'b0; bus.membus_addr_ack = 1'b1;
    #1;
    @(negedge clk);
    bus.membus_addr_ack = 1'b0;
    #1;
    check("rst_mid.mb_out_before", bus.membus_mb_out, 36'o1234);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid.mb_out", bus.membus_mb_out, 0);
    check("rst_mid.wr_rs",  bus.membus_wr_rs, 0);
    check("rst_mid.busy",   bus.busy, 0);
    check("rst_mid.rq_cyc", bus.membus_rq_cyc, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    run_txn("post_reset", 1'b1, 1'b1, 18'o000210, 1'b0, 36'o4321, 36'o1111, 1, 1, 1);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      mode  = $urandom_range(0, 2);
      rd    = (mode != 1);
      wr    = (mode != 0);
      a     = ($urandom_range(0, 7) == 0) ? NXM_CYC : $urandom_range(0, 5);
      r     = ($urandom_range(0, 9) == 0) ? RS_CYC : $urandom_range(0, 6);
      s     = $urandom_range(0, 4);
      wd    = ($urandom_range(0, 7) == 0) ? '0 : rnd36();
      rdval = rnd36();
      addr  = ($urandom_range(0, 3) == 0) ? {14'd0, rnd18()[32:35]} : rnd18();
      fmc   = ($urandom_range(0, 1) == 1);
      run_txn($sformatf("rnd%0d", i), rd, wr, addr, fmc, wd, rdval, a, r, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute safety net so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
